dispatch_fifo: RTL and testbench
================================

Name: dispatch_fifo

Overview:
- Circular show-ahead FIFO between decode/dispatch and register-read.
- One instance per issue-queue type (alu, mem). Each instance buffers decoded queue_item_t entries pushed by dispatch and presents the oldest entry to register-read.
- Supports a same-cycle push and pop.
- Supports a single-cycle flush for front-end and execute redirects.

Parameters:
- WIDTH, 32: entry width in bits; instantiated as $bits(queue_item_t).
- DEPTH, 8: number of entries; must be a power of two, >= 2.
- CNTW, $clog2(DEPTH)+1: occupancy counter width (derived, not overridden).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-high.
- flush  input  1  discard all entries this cycle.
- push  input  1  dispatch requests to enqueue din.
- din  input  WIDTH  entry to enqueue.
- pop  input  1  register-read consumes the head entry.
- dout  output  WIDTH  head entry (oldest); valid when !empty.
- empty  output  1  no entries held.
- full  output  1  DEPTH entries held.
- count  output  CNTW  current occupancy, 0..DEPTH.
- push_ok  output  1  push accepted this cycle (combinational).
- pop_ok  output  1  pop accepted this cycle (combinational).

Behaviour:
- Storage is DEPTH x WIDTH registers, with head pointer rd_ptr and tail pointer wr_ptr, each log2(DEPTH) bits.
- Pointers wrap modulo DEPTH through natural overflow.
- Reset (rst=1 at posedge): rd_ptr=0, wr_ptr=0, count=0.
  - After reset: empty=1, full=0, dout=0.
  - Storage contents are not reset; dout is forced to 0 whenever empty.
- Outputs: empty = (count==0); full = (count==DEPTH). Both are derived from registered count (no combinational path from push/pop).
- dout = mem[rd_ptr] when !empty, else 0.
  - Show-ahead: an entry pushed in cycle N appears on dout in cycle N+1 if the FIFO was empty.
- pop_ok = pop & !empty & !flush.
  - A pop while empty is ignored, with no pointer or count change.
- push_ok = push & !flush & (!full | pop_ok).
  - Push while full is accepted only when a pop is accepted in the same cycle.
  - Otherwise the push is dropped and din is not stored. Dispatch is required to stall on full.
- Update on posedge when no reset and no flush:
  - push_ok writes mem[wr_ptr]=din and sets wr_ptr+=1.
  - pop_ok sets rd_ptr+=1.
  - count += push_ok - pop_ok.
  - When both are accepted, count is unchanged and both pointers advance.
- Simultaneous push and pop when count==1: the head is consumed and the new entry becomes head next cycle; empty stays 0.
- Flush (flush=1, rst=0):
  - Next cycle: rd_ptr=0, wr_ptr=0, count=0.
  - push and pop in the flush cycle are ignored; push_ok=pop_ok=0.
- Precedence: rst > flush > push/pop.
- Reset or flush mid-stream discards all entries; no partial retention.
- Latency: push to visible on dout is 1 cycle; pop to next head visible is 1 cycle.
- Invariants:
  - count never exceeds DEPTH and never underflows.
  - wr_ptr - rd_ptr (mod DEPTH) == count mod DEPTH.

Test Plan:
- Reset then idle: assert rst one cycle -> empty=1, full=0, count=0, dout=0; pop with empty -> count stays 0, pop_ok=0.
- Fill/drain order: push 0x11,0x22,...,0x88 (DEPTH=8) on consecutive cycles -> full=1, count=8 after the 8th; 9th push 0x99 -> push_ok=0. Then pop 8 times -> dout sequence 0x11..0x88, empty=1 after the last.
- Wrap-around: push 5, pop 5, then push 6 values 0xA0..0xA5 -> pointers wrap past index 7; pops return 0xA0..0xA5 in order, count returns to 0.
- Simultaneous push/pop at full: fill with 0x01..0x08, then push 0x09 with pop -> push_ok=pop_ok=1, count stays 8, dout next=0x02; draining yields 0x02..0x09.
- Simultaneous push/pop at count==1: holding 0x55, push 0x66 and pop together -> next cycle dout=0x66, count=1, empty=0.
- Flush mid-stream: holding 3 entries, assert flush with push=1, pop=1 -> push_ok=pop_ok=0; next cycle empty=1, count=0. A subsequent push 0x77 -> dout=0x77 the following cycle.

Source files
------------

// File: rtl/dispatch_fifo.sv
// Circular show-ahead FIFO between decode/dispatch and register-read.
// One instance per issue-queue type. The oldest entry is always presented on
// dout, so register-read can inspect it before deciding to pop. A
// synchronous flush empties the queue in one cycle on a redirect.
module dispatch_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 8,
  localparam int CNTW  = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [CNTW-1:0]  count,
  output logic             push_ok,
  output logic             pop_ok
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNTW-1:0]  count_q,  count_d;

  // Status flags come only from registered occupancy, so they never depend
  // on this cycle's push/pop requests.
  assign empty = (count_q == '0);
  assign full  = (count_q == CNTW'(DEPTH));
  assign count = count_q;

  // Head entry; forced to zero when empty because storage is never cleared.
  assign dout = empty ? '0 : mem_q[rd_ptr_q];

  // Handshake: flush wins over everything, and a push into a full queue is
  // accepted only when the head is leaving in the same cycle.
  assign pop_ok  = pop  & ~empty & ~flush;
  assign push_ok = push & ~flush & (~full | pop_ok);

  // Next-state pointers and occupancy.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap modulo DEPTH by natural overflow of their PW bits.
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNTW'(push_ok) - CNTW'(pop_ok);
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage write at the tail.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; empty masks stale contents on dout, and pointers/count define validity.
    if (!rst && push_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: tb/tb_dispatch_fifo.sv
// Directed bench for dispatch_fifo (WIDTH=32, DEPTH=8). Inputs change 1 ns
// after a rising edge; combinational handshakes are sampled after a further
// 1 ns, registered outputs 1 ns after the following edge.
module tb_dispatch_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int CNTW  = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst, flush, push, pop;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             empty, full, push_ok, pop_ok;
  logic [CNTW-1:0]  count;

  int n_assert = 0;
  int n_fail   = 0;

  dispatch_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .push   (push),
    .din    (din),
    .pop    (pop),
    .dout   (dout),
    .empty  (empty),
    .full   (full),
    .count  (count),
    .push_ok(push_ok),
    .pop_ok (pop_ok)
  );

  always #5 clk = ~clk;

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic p, input logic [31:0] d, input logic o, input logic f);
    push  = p;
    din   = d;
    pop   = o;
    flush = f;
    #1;
  endtask

  task automatic chk_state(input string tag, input logic e, input logic fu,
                           input logic [31:0] c, input logic [31:0] d);
    chk({tag, ".empty"}, {31'd0, empty}, {31'd0, e});
    chk({tag, ".full"},  {31'd0, full},  {31'd0, fu});
    chk({tag, ".count"}, {28'd0, count}, c);
    chk({tag, ".dout"},  dout, d);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; push = 1'b0; pop = 1'b0; din = '0;

    // Reset then idle.
    tick();
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk_state("reset", 1'b1, 1'b0, 0, 32'h0);

    // Pop while empty is ignored.
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    chk("pop_empty.pop_ok", {31'd0, pop_ok}, 32'd0);
    tick();
    chk_state("pop_empty", 1'b1, 1'b0, 0, 32'h0);

    // Fill with 0x11..0x88; show-ahead head after the first push.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 32'h11 * i, 1'b0, 1'b0);
      chk("fill.push_ok", {31'd0, push_ok}, 32'd1);
      tick();
      chk("fill.dout", dout, 32'h11);
      chk("fill.count", {28'd0, count}, i);
    end
    chk_state("full", 1'b0, 1'b1, 8, 32'h11);

    // Ninth push is dropped.
    drive(1'b1, 32'h99, 1'b0, 1'b0);
    chk("overflow.push_ok", {31'd0, push_ok}, 32'd0);
    tick();
    chk_state("overflow", 1'b0, 1'b1, 8, 32'h11);

    // Drain in order.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      chk("drain.dout", dout, 32'h11 * i);
      chk("drain.pop_ok", {31'd0, pop_ok}, 32'd1);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk_state("drained", 1'b1, 1'b0, 0, 32'h0);

    // Wrap-around: advance pointers by 5, then push 6 across index 7.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h30 + i, 1'b0, 1'b0);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      chk("wrap_pre.dout", dout, 32'h30 + i);
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'hA0 + i, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk_state("wrap_loaded", 1'b0, 1'b0, 6, 32'hA0);
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      chk("wrap.dout", dout, 32'hA0 + i);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk_state("wrap_done", 1'b1, 1'b0, 0, 32'h0);

    // Simultaneous push/pop at full.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, i, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'h09, 1'b1, 1'b0);
    chk("full_pp.push_ok", {31'd0, push_ok}, 32'd1);
    chk("full_pp.pop_ok",  {31'd0, pop_ok},  32'd1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk_state("full_pp", 1'b0, 1'b1, 8, 32'h02);
    for (int i = 2; i <= 9; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      chk("full_pp_drain.dout", dout, i);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk_state("full_pp_done", 1'b1, 1'b0, 0, 32'h0);

    // Simultaneous push/pop with a single entry.
    drive(1'b1, 32'h55, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h66, 1'b1, 1'b0);
    chk("one_pp.pop_ok",  {31'd0, pop_ok},  32'd1);
    chk("one_pp.push_ok", {31'd0, push_ok}, 32'd1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk_state("one_pp", 1'b0, 1'b0, 1, 32'h66);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk_state("one_pp_done", 1'b1, 1'b0, 0, 32'h0);

    // Flush mid-stream with push and pop asserted.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hC1 + i, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'hEE, 1'b1, 1'b1);
    chk("flush.push_ok", {31'd0, push_ok}, 32'd0);
    chk("flush.pop_ok",  {31'd0, pop_ok},  32'd0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk_state("flushed", 1'b1, 1'b0, 0, 32'h0);
    drive(1'b1, 32'h77, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk_state("post_flush", 1'b0, 1'b0, 1, 32'h77);

    // Reset mid-stream beats a concurrent push.
    drive(1'b1, 32'h88, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    drive(1'b1, 32'h99, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk_state("mid_reset", 1'b1, 1'b0, 0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
